// File: rtl/param_alu_pkg.sv
// Shared constants, FSM state type and helpers for the sequential integer ALU.
// Helpers work on MAX_W-bit values, so WIDTH must stay below MAX_W.
package param_alu_pkg;
  localparam int MAX_W = 64;

  localparam logic [3:0] OP_ADD = 4'b1000;
  localparam logic [3:0] OP_SUB = 4'b0100;
  localparam logic [3:0] OP_MUL = 4'b0010;
  localparam logic [3:0] OP_DIV = 4'b0001;

  typedef enum logic [1:0] {IDLE, MUL_IT, DIV_IT, DIV_FIX} state_t;

  // Callers sign-extend (or zero-extend) to MAX_W bits first.
  function automatic logic [MAX_W-1:0] mag(input logic [MAX_W-1:0] v);
    return v[MAX_W-1] ? (~v + 1'b1) : v;
  endfunction

  function automatic logic is_onehot(input logic [3:0] o);
    return (o != 4'b0000) && ((o & (o - 4'd1)) == 4'b0000);
  endfunction
endpackage

// File: rtl/param_alu_if.sv
// Request/result bundle between the operand registers and the ALU.
// Handshake: a request is taken on a rising edge where start=1 and busy=0; done pulses
// for one cycle when res_hi/res_lo/flags become valid, and they hold until the next take.
interface param_alu_if #(parameter int WIDTH = 8);
  import param_alu_pkg::*;

  logic             start;
  logic [3:0]       op;
  logic             sign;
  logic [WIDTH-1:0] data1;
  logic [WIDTH-1:0] data2;
  logic [WIDTH-1:0] res_hi;
  logic [WIDTH-1:0] res_lo;
  logic             ovf;
  logic             dz;
  logic             bad_op;
  logic             busy;
  logic             done;
  state_t           dbg_state;

  modport master (output start, op, sign, data1, data2,
                  input  res_hi, res_lo, ovf, dz, bad_op, busy, done, dbg_state);
  modport slave  (input  start, op, sign, data1, data2,
                  output res_hi, res_lo, ovf, dz, bad_op, busy, done, dbg_state);
endinterface

// File: rtl/param_alu_div_step.sv
// One restoring-division step: shift the next dividend bit into the partial remainder
// and subtract the divisor if it fits.
module param_alu_div_step #(parameter int WIDTH = 8) (
  input  logic [WIDTH:0]   rem_in,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_out,
  output logic             q_bit
);
  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] diff;

  assign shifted = {rem_in, bit_in};
  assign diff    = shifted - {2'b00, divisor};
  assign q_bit   = ~diff[WIDTH+1];
  assign rem_out = q_bit ? diff[WIDTH:0] : shifted[WIDTH:0];
endmodule

// File: rtl/param_alu.sv
// Sequential ALU: single-cycle add/sub, radix-2 Booth multiply, restoring divide.
// An accepted request spends one "pending" cycle in IDLE before it completes or iterates.
module param_alu
  import param_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic         clk,
  input logic         rst,
  param_alu_if.slave  bus
);
  localparam int CW = $clog2(WIDTH + 2);
  localparam logic [CW-1:0] LAST_MUL = CW'(WIDTH);
  localparam logic [CW-1:0] LAST_DIV = CW'(WIDTH - 1);

  state_t           state, state_n;
  logic             pend;
  logic [CW-1:0]    cnt;
  logic [3:0]       op_r;
  logic             sign_r;
  logic [WIDTH-1:0] a_r, b_r;
  logic [WIDTH:0]   acc, mq, mm, mm_neg;
  logic             mq1;
  logic [WIDTH:0]   rem, rem_n;
  logic [WIDTH-1:0] dq, dsr;
  logic             q_bit, neg_q, neg_r, min_ovf;
  logic             busy, accept;
  logic [WIDTH:0]   in1, in2, la, lb, addsub, acc_sum, acc_n, mq_n;
  logic [MAX_W-1:0] a_mag, b_mag;
  logic             unused_mag_hi;

  assign busy          = (state != IDLE) || pend;
  assign accept        = bus.start && !busy;
  assign bus.busy      = busy;
  assign bus.dbg_state = state;

  always_comb begin
    in1     = {bus.sign & bus.data1[WIDTH-1], bus.data1};
    in2     = {bus.sign & bus.data2[WIDTH-1], bus.data2};
    a_mag   = mag({{(MAX_W-WIDTH){bus.sign & bus.data1[WIDTH-1]}}, bus.data1});
    b_mag   = mag({{(MAX_W-WIDTH){bus.sign & bus.data2[WIDTH-1]}}, bus.data2});
    la      = {sign_r & a_r[WIDTH-1], a_r};
    lb      = {sign_r & b_r[WIDTH-1], b_r};
    addsub  = (op_r == OP_SUB) ? (la - lb) : (la + lb);
    // Booth recoding of the multiplier LSB pair, then arithmetic shift of {acc, mq, mq1}
    case ({mq[0], mq1})
      2'b01:   acc_sum = acc + mm;
      2'b10:   acc_sum = acc + mm_neg;
      default: acc_sum = acc;
    endcase
    acc_n = {acc_sum[WIDTH], acc_sum[WIDTH:1]};
    mq_n  = {acc_sum[0], mq[WIDTH:1]};
  end

  assign unused_mag_hi = ^{a_mag[MAX_W-1:WIDTH], b_mag[MAX_W-1:WIDTH]};

  param_alu_div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem_in  (rem),
    .bit_in  (dq[WIDTH-1]),
    .divisor (dsr),
    .rem_out (rem_n),
    .q_bit   (q_bit)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (pend && op_r == OP_MUL)                      state_n = MUL_IT;
        else if (pend && op_r == OP_DIV && b_r != '0)    state_n = DIV_IT;
      end
      MUL_IT:  if (cnt == LAST_MUL) state_n = IDLE;
      DIV_IT:  if (cnt == LAST_DIV) state_n = DIV_FIX;
      DIV_FIX: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend <= 1'b0;  cnt <= '0;  op_r <= '0;  sign_r <= 1'b0;
      a_r <= '0;  b_r <= '0;  acc <= '0;  mq <= '0;  mq1 <= 1'b0;
      mm <= '0;  mm_neg <= '0;  rem <= '0;  dq <= '0;  dsr <= '0;
      neg_q <= 1'b0;  neg_r <= 1'b0;  min_ovf <= 1'b0;
      bus.res_hi <= '0;  bus.res_lo <= '0;  bus.ovf <= 1'b0;
      bus.dz <= 1'b0;  bus.bad_op <= 1'b0;  bus.done <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      if (accept) begin
        pend   <= 1'b1;  cnt <= '0;
        op_r   <= bus.op;  sign_r <= bus.sign;
        a_r    <= bus.data1;  b_r <= bus.data2;
        mm     <= in1;  mm_neg <= ~in1 + 1'b1;
        acc    <= '0;  mq <= in2;  mq1 <= 1'b0;
        rem    <= '0;  dq <= a_mag[WIDTH-1:0];  dsr <= b_mag[WIDTH-1:0];
        neg_q  <= bus.sign & (bus.data1[WIDTH-1] ^ bus.data2[WIDTH-1]);
        neg_r  <= bus.sign & bus.data1[WIDTH-1];
        min_ovf <= bus.sign && (bus.data1 == {1'b1, {(WIDTH-1){1'b0}}}) && (bus.data2 == '1);
        bus.res_hi <= '0;  bus.res_lo <= '0;  bus.ovf <= 1'b0;
        bus.dz <= 1'b0;  bus.bad_op <= 1'b0;
      end else if (pend) begin
        pend <= 1'b0;
        if (!is_onehot(op_r)) begin
          bus.bad_op <= 1'b1;
          bus.done   <= 1'b1;
        end else if (op_r == OP_ADD || op_r == OP_SUB) begin
          bus.res_lo <= addsub[WIDTH-1:0];
          bus.res_hi <= sign_r ? {WIDTH{addsub[WIDTH-1]}} : {{(WIDTH-1){1'b0}}, addsub[WIDTH]};
          bus.ovf    <= sign_r ? (addsub[WIDTH] ^ addsub[WIDTH-1]) : addsub[WIDTH];
          bus.done   <= 1'b1;
        end else if (op_r == OP_DIV && b_r == '0) begin
          bus.res_lo <= '1;
          bus.res_hi <= a_r;
          bus.dz     <= 1'b1;
          bus.done   <= 1'b1;
        end
      end else begin
        case (state)
          MUL_IT: begin
            acc <= acc_n;  mq <= mq_n;  mq1 <= mq[0];  cnt <= cnt + 1'b1;
            if (cnt == LAST_MUL) begin
              bus.res_hi <= {acc_n[WIDTH-2:0], mq_n[WIDTH]};
              bus.res_lo <= mq_n[WIDTH-1:0];
              bus.done   <= 1'b1;
            end
          end
          DIV_IT: begin
            rem <= rem_n;  dq <= {dq[WIDTH-2:0], q_bit};  cnt <= cnt + 1'b1;
          end
          DIV_FIX: begin
            // Quotient truncates toward zero; remainder follows the dividend's sign
            bus.res_lo <= neg_q ? (~dq + 1'b1) : dq;
            bus.res_hi <= neg_r ? (~rem[WIDTH-1:0] + 1'b1) : rem[WIDTH-1:0];
            bus.ovf    <= min_ovf;
            bus.done   <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_param_alu.sv
// Directed bench for param_alu at WIDTH=8: latency, results and flags per scenario.
module tb_param_alu;
  import param_alu_pkg::*;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  param_alu_if #(.WIDTH(W)) bus();
  param_alu #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic launch(input logic [3:0] op, input logic s, input logic [W-1:0] d1, input logic [W-1:0] d2);
    @(negedge clk);
    bus.start = 1'b1;  bus.op = op;  bus.sign = s;  bus.data1 = d1;  bus.data2 = d2;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    bus.start = 1'b0;  bus.op = '0;  bus.sign = 1'b0;  bus.data1 = '0;  bus.data2 = '0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total_cnt++;
    if ({bus.busy, bus.done, bus.res_hi, bus.res_lo, bus.ovf, bus.dz, bus.bad_op} !== '0)
      $display("FAIL reset_outputs: got %h expected 0",
               {bus.busy, bus.done, bus.res_hi, bus.res_lo, bus.ovf, bus.dz, bus.bad_op});
    else pass_cnt++;
    total_cnt++;
    if (bus.dbg_state !== IDLE) $display("FAIL reset_state: got %0d expected %0d", bus.dbg_state, IDLE);
    else pass_cnt++;
    @(negedge clk) rst = 1'b1;
  endtask

  task automatic test_addsub();
    logic [3:0]  ops [5] = '{OP_ADD, OP_ADD, OP_SUB, OP_SUB, OP_ADD};
    logic        sg  [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [7:0]  d1  [5] = '{8'h7F, 8'hFF, 8'h03, 8'h05, 8'h80};
    logic [7:0]  d2  [5] = '{8'h01, 8'h01, 8'h05, 8'h07, 8'hFF};
    logic [16:0] exp_r [5] = '{17'h1FF80, 17'h10100, 17'h101FE, 17'h0FFFE, 17'h1007F};
    int lat;
    for (int i = 0; i < 5; i++) begin
      launch(ops[i], sg[i], d1[i], d2[i]);
      wait_done(lat);
      total_cnt++;
      if (lat !== 1) $display("FAIL addsub_lat[%0d]: got %0d expected 1", i, lat);
      else pass_cnt++;
      total_cnt++;
      if ({bus.ovf, bus.res_hi, bus.res_lo} !== exp_r[i])
        $display("FAIL addsub_res[%0d]: got %h expected %h", i, {bus.ovf, bus.res_hi, bus.res_lo}, exp_r[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_mul();
    logic        sg  [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [7:0]  d1  [5] = '{8'h80, 8'hFF, 8'hFF, 8'h0C, 8'h7F};
    logic [7:0]  d2  [5] = '{8'h80, 8'hFF, 8'h02, 8'h0A, 8'h81};
    logic [16:0] exp_r [5] = '{17'h04000, 17'h0FE01, 17'h0FFFE, 17'h00078, 17'h0C0FF};
    int lat;
    for (int i = 0; i < 5; i++) begin
      launch(OP_MUL, sg[i], d1[i], d2[i]);
      wait_done(lat);
      total_cnt++;
      if (lat !== 10) $display("FAIL mul_lat[%0d]: got %0d expected 10", i, lat);
      else pass_cnt++;
      total_cnt++;
      if ({bus.ovf, bus.res_hi, bus.res_lo} !== exp_r[i])
        $display("FAIL mul_res[%0d]: got %h expected %h", i, {bus.ovf, bus.res_hi, bus.res_lo}, exp_r[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_div();
    logic        sg  [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [7:0]  d1  [6] = '{8'hF9, 8'hF9, 8'h07, 8'h80, 8'h64, 8'hF9};
    logic [7:0]  d2  [6] = '{8'h02, 8'h02, 8'hFE, 8'hFF, 8'h07, 8'hFE};
    logic [17:0] exp_r [6] = '{18'h0FFFD, 18'h0017C, 18'h001FD, 18'h10080, 18'h0020E, 18'h0FF03};
    int lat;
    for (int i = 0; i < 6; i++) begin
      launch(OP_DIV, sg[i], d1[i], d2[i]);
      wait_done(lat);
      total_cnt++;
      if (lat !== 10) $display("FAIL div_lat[%0d]: got %0d expected 10", i, lat);
      else pass_cnt++;
      total_cnt++;
      if ({bus.dz, bus.ovf, bus.res_hi, bus.res_lo} !== exp_r[i])
        $display("FAIL div_res[%0d]: got %h expected %h", i, {bus.dz, bus.ovf, bus.res_hi, bus.res_lo}, exp_r[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_div_zero();
    logic       sg [2] = '{1'b0, 1'b1};
    logic [7:0] d1 [2] = '{8'h05, 8'h80};
    logic [17:0] exp_r [2] = '{18'h205FF, 18'h280FF};
    int lat;
    for (int i = 0; i < 2; i++) begin
      launch(OP_DIV, sg[i], d1[i], 8'h00);
      wait_done(lat);
      total_cnt++;
      if (lat !== 1) $display("FAIL divzero_lat[%0d]: got %0d expected 1", i, lat);
      else pass_cnt++;
      total_cnt++;
      if ({bus.dz, bus.ovf, bus.res_hi, bus.res_lo} !== exp_r[i])
        $display("FAIL divzero_res[%0d]: got %h expected %h", i, {bus.dz, bus.ovf, bus.res_hi, bus.res_lo}, exp_r[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_bad_op();
    logic [3:0] ops [2] = '{4'b0011, 4'b0000};
    int lat;
    for (int i = 0; i < 2; i++) begin
      launch(ops[i], 1'b1, 8'h12, 8'h34);
      wait_done(lat);
      total_cnt++;
      if (lat !== 1) $display("FAIL badop_lat[%0d]: got %0d expected 1", i, lat);
      else pass_cnt++;
      total_cnt++;
      if ({bus.bad_op, bus.dz, bus.ovf, bus.res_hi, bus.res_lo} !== 19'h40000)
        $display("FAIL badop_res[%0d]: got %h expected 40000", i, {bus.bad_op, bus.dz, bus.ovf, bus.res_hi, bus.res_lo});
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    launch(OP_MUL, 1'b1, 8'hFD, 8'h07);
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    total_cnt++;
    if ({bus.busy, bus.done, bus.res_hi, bus.res_lo} !== '0 || bus.dbg_state !== IDLE)
      $display("FAIL reset_mid: got %h state %0d expected 0 state 0",
               {bus.busy, bus.done, bus.res_hi, bus.res_lo}, bus.dbg_state);
    else pass_cnt++;
    @(negedge clk) rst = 1'b1;
    launch(OP_MUL, 1'b1, 8'hFD, 8'h07);
    wait_done(lat);
    total_cnt++;
    if (lat !== 10 || {bus.res_hi, bus.res_lo} !== 16'hFFEB)
      $display("FAIL reset_mid_rerun: got lat %0d res %h expected lat 10 res ffeb", lat, {bus.res_hi, bus.res_lo});
    else pass_cnt++;
  endtask

  task automatic test_busy_ignore();
    int lat;
    int extra = 0;
    launch(OP_MUL, 1'b0, 8'h0C, 8'h0A);
    @(negedge clk);
    bus.start = 1'b1;  bus.op = OP_ADD;  bus.data1 = 8'h55;  bus.data2 = 8'h11;
    @(posedge clk);
    #1 bus.start = 1'b0;
    wait_done(lat);
    total_cnt++;
    if (lat !== 9 || {bus.res_hi, bus.res_lo} !== 16'h0078)
      $display("FAIL busy_ignore: got lat %0d res %h expected lat 9 res 0078", lat, {bus.res_hi, bus.res_lo});
    else pass_cnt++;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1 if (bus.done === 1'b1) extra++;
    end
    total_cnt++;
    if (extra !== 0) $display("FAIL no_queue: got %0d extra done pulses expected 0", extra);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int lat;
    launch(OP_ADD, 1'b0, 8'h10, 8'h20);
    wait_done(lat);
    total_cnt++;
    if (lat !== 1 || {bus.ovf, bus.res_hi, bus.res_lo} !== 17'h00030)
      $display("FAIL b2b_first: got lat %0d res %h expected lat 1 res 00030", lat, {bus.ovf, bus.res_hi, bus.res_lo});
    else pass_cnt++;
    bus.start = 1'b1;  bus.op = OP_SUB;  bus.sign = 1'b1;  bus.data1 = 8'h05;  bus.data2 = 8'h07;
    @(posedge clk);
    #1 bus.start = 1'b0;
    total_cnt++;
    if ({bus.busy, bus.done, bus.res_lo} !== 10'h200)
      $display("FAIL b2b_accept: got busy/done/lo %h expected 200", {bus.busy, bus.done, bus.res_lo});
    else pass_cnt++;
    wait_done(lat);
    total_cnt++;
    if (lat !== 1 || {bus.ovf, bus.res_hi, bus.res_lo} !== 17'h0FFFE)
      $display("FAIL b2b_second: got lat %0d res %h expected lat 1 res 0fffe", lat, {bus.ovf, bus.res_hi, bus.res_lo});
    else pass_cnt++;
  endtask

  task automatic test_data_change();
    int lat;
    launch(OP_DIV, 1'b0, 8'h64, 8'h07);
    @(negedge clk);
    bus.data1 = 8'hFF;  bus.data2 = 8'h01;  bus.op = OP_ADD;  bus.sign = 1'b1;
    wait_done(lat);
    total_cnt++;
    if (lat !== 10 || {bus.res_hi, bus.res_lo} !== 16'h020E)
      $display("FAIL data_change: got lat %0d res %h expected lat 10 res 020e", lat, {bus.res_hi, bus.res_lo});
    else pass_cnt++;
    @(posedge clk);
    #1;
    total_cnt++;
    if ({bus.done, bus.res_hi, bus.res_lo} !== 17'h0020E)
      $display("FAIL result_hold: got %h expected 0020e", {bus.done, bus.res_hi, bus.res_lo});
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_addsub();
    test_mul();
    test_div();
    test_div_zero();
    test_bad_op();
    test_reset_mid();
    test_busy_ignore();
    test_back_to_back();
    test_data_change();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
